spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per SPI frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sck/ss/mosi, legal range 2..4.
REQ-003 SHALL have port clk  input  1  system clock, the single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port d  input  DATA_WIDTH  parallel word to transmit on miso.
REQ-006 SHALL have port load  input  1  one-cycle strobe; d is captured into tx buffer when high.
REQ-007 SHALL have port ss  input  1  asynchronous slave select from master, active-low.
REQ-008 SHALL have port sck  input  1  asynchronous SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-009 SHALL have port mosi  input  1  asynchronous serial data from master.
REQ-010 SHALL have port miso  output  1  serial data to master.
REQ-011 SHALL have port q  output  DATA_WIDTH  last complete received word.
REQ-012 SHALL have port finished  output  1  one-cycle pulse when q is updated.
REQ-013 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-014 ss, sck and mosi SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals, compared with one further flop.
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE->SHIFT SHALL occur on the cycle a synchronized ss falling edge is detected: shift-out register loaded from tx buffer, bit counter cleared, busy high.
REQ-017 miso SHALL present the first tx bit while in SHIFT before the first sck rise, and SHALL be 1 whenever the FSM is in IDLE.
REQ-018 On each synchronized sck rising edge, mosi SHALL be shifted into the receive register and the bit counter incremented.
REQ-019 On each synchronized sck falling edge, the shift-out register SHALL advance, updating miso.
REQ-020 On the rising edge completing bit DATA_WIDTH, the FSM SHALL go SHIFT->DONE; in DONE, q SHALL take the receive word and finished SHALL be high for exactly that one cycle.
REQ-021 DONE->SHIFT SHALL occur on the next cycle if ss is still low (back-to-back frame): counter cleared and shift-out reloaded from tx buffer at the next sck falling edge. DONE->IDLE SHALL occur otherwise.
REQ-022 Default order SHALL be MSB first for both directions.
REQ-023 load SHALL update only the tx buffer, never the active shift-out register. A load on the same cycle as a reload SHALL supply the new d to the reload.
REQ-024 With no load between frames, the tx buffer SHALL be retransmitted unchanged.
REQ-025 A synchronized ss rise in SHIFT (partial frame) SHALL go to IDLE: no finished pulse, q unchanged, busy low, partial bits discarded.
REQ-026 sck edges while ss is high SHALL be ignored.
REQ-027 Operation SHALL be correct only while sck high and low times are each >= SYNC_STAGES+2 clk periods.

Reset
REQ-028 With reset high at a clk edge, the block SHALL go to state IDLE and drive miso=1, q=0, finished=0, busy=0.
REQ-029 Reset SHALL clear the tx buffer to 0 and the bit counter to 0, preset the ss sync flops to 1 and the sck sync flops to 0, and abort any frame in progress without a finished pulse.

Configuration
REQ-030 With SPI_SLAVE_LSB_FIRST_EN defined, both the shift-in and shift-out SHALL be LSB first.
REQ-031 Without SPI_SLAVE_LSB_FIRST_EN, both directions SHALL be MSB first; no other behaviour SHALL change.

Structure
REQ-032 Package spi_pkg SHALL hold the DATA_WIDTH default constant and the FSM state typedef (IDLE, SHIFT, DONE).
REQ-033 Sub-module spi_sync SHALL implement the synchronizer plus rise/fall detect, instantiated once each for sck, ss and mosi (edge outputs unused for mosi).

Verification
REQ-034 Reset, load d=8'h41, master frame 0xA5 -> miso bits 0,1,0,0,0,0,0,1; q=0xA5; exactly one finished pulse.
REQ-035 ss held low, frames 0x3C then 0xC3, load 0x55 during first frame -> q=0x3C then 0xC3, miso 0x41 then 0x55, two finished pulses.
REQ-036 ss raised after 5 sck rises -> no finished, q keeps previous value, busy low; next full frame 0x96 -> q=0x96.
REQ-037 reset pulsed after 4 bits -> miso=1, q=0, busy=0, no finished; next frame 0x0F after load 0xF0 -> q=0x0F, miso sends 0xF0.
REQ-038 Two frames 0x11, 0x22 with no load after d=0x41 -> miso sends 0x41 twice.
REQ-039 SPI_SLAVE_LSB_FIRST_EN defined, load 0x41, master LSB-first 0xA5 -> miso 1,0,0,0,0,0,1,0; q=0xA5.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave.
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input with rise/fall detection
// on the synchronized level (compared against one extra flop).
module spi_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave oversampled by the system clock. Bit order is MSB first
// unless SPI_SLAVE_LSB_FIRST_EN is defined, which makes both directions LSB first.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  load,
  input  logic                  ss,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  finished,
  output logic                  busy
);

  localparam int            CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  // Handshake: load is a single-cycle strobe with no back-pressure; finished
  // is a single-cycle valid for q with no ready -- the consumer must take it.

  state_t                state;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic [DATA_WIDTH-1:0] shift_out;
  logic [DATA_WIDTH-1:0] rx;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] reload_val;
  logic [CW-1:0]         cnt;
  logic                  reload_pending;

  logic ss_s, ss_rise, ss_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(ss),
    .sync(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .din(sck),
    .sync(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .sync(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  // First bit on the wire for a freshly loaded shift word.
  function automatic logic head(input logic [DATA_WIDTH-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_WIDTH-1];
`endif
  endfunction

  always_comb begin
    reload_val = load ? d : tx_buf;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    rx_next    = {mosi_s, rx[DATA_WIDTH-1:1]};
    shift_next = shift_out >> 1;
`else
    rx_next    = {rx[DATA_WIDTH-2:0], mosi_s};
    shift_next = shift_out << 1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tx_buf         <= '0;
      shift_out      <= '0;
      rx             <= '0;
      cnt            <= '0;
      reload_pending <= 1'b0;
      miso           <= 1'b1;
      q              <= '0;
      finished       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (load) tx_buf <= d;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state          <= SHIFT;
            shift_out      <= reload_val;
            miso           <= head(reload_val);
            cnt            <= '0;
            rx             <= '0;
            reload_pending <= 1'b0;
            busy           <= 1'b1;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state          <= IDLE;
            busy           <= 1'b0;
            miso           <= 1'b1;
            reload_pending <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx  <= rx_next;
              cnt <= cnt + 1'b1;
              if (cnt == LAST) begin
                state    <= DONE;
                q        <= rx_next;
                finished <= 1'b1;
              end
            end
            // After a completed frame the next falling edge starts a new word.
            if (sck_fall) begin
              if (reload_pending) begin
                shift_out      <= reload_val;
                miso           <= head(reload_val);
                reload_pending <= 1'b0;
              end else begin
                shift_out <= shift_next;
                miso      <= head(shift_next);
              end
            end
          end
        end
        DONE: begin
          if (!ss_s) begin
            state          <= SHIFT;
            cnt            <= '0;
            reload_pending <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master tasks plus a finished/q scoreboard.
// Bit order follows SPI_SLAVE_LSB_FIRST_EN.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] d = '0;
  logic         load = 1'b0;
  logic         ss = 1'b1;
  logic         sck = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] q;
  logic         finished;
  logic         busy;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int fin_cnt   = 0;

  logic [W-1:0] exp_q[$];

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .d(d), .load(load), .ss(ss), .sck(sck),
    .mosi(mosi), .miso(miso), .q(q), .finished(finished), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: every finished pulse must match the oldest expected word
  always @(negedge clk) begin
    if (finished === 1'b1) begin
      fin_cnt++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: unexpected finished, q=%h", q);
      end else begin
        automatic logic [W-1:0] e = exp_q.pop_front();
        if (q !== e) $display("FAIL scoreboard_q: got %h want %h", q, e);
        else pass_cnt++;
      end
    end
  end

  // driver tasks
  task automatic pulse_load(input logic [W-1:0] v);
    d    = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [W-1:0] mo, input int nbits,
                          input logic do_load, input logic [W-1:0] ld,
                          output logic [W-1:0] mi, output logic busy_ok);
    int idx;
    mi = '0;
    busy_ok = 1'b1;
    for (int k = 0; k < nbits; k++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      idx = k;
`else
      idx = W - 1 - k;
`endif
      mosi = mo[idx];
      repeat (HALF) @(negedge clk);
      mi[idx] = miso;
      busy_ok = busy_ok & (busy === 1'b1);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
      if (do_load && k == 3) pulse_load(ld);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cnt++; if (miso !== 1'b1) $display("FAIL reset_miso: got %b want 1", miso); else pass_cnt++;
    check_cnt++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else pass_cnt++;
    check_cnt++; if (finished !== 1'b0) $display("FAIL reset_finished: got %b want 0", finished); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] mi;
    logic bo;
    int f0;
    f0 = fin_cnt;
    pulse_load(8'h41);
    ss_low();
    exp_q.push_back(8'hA5);
    spi_bits(8'hA5, W, 1'b0, 8'h00, mi, bo);
    ss_high();
    check_cnt++; if (mi !== 8'h41) $display("FAIL single_miso: got %h want 41", mi); else pass_cnt++;
    check_cnt++; if (bo !== 1'b1) $display("FAIL single_busy_mid: got %b want 1", bo); else pass_cnt++;
    check_cnt++; if (q !== 8'hA5) $display("FAIL single_q: got %h want a5", q); else pass_cnt++;
    check_cnt++; if (fin_cnt - f0 != 1) $display("FAIL single_pulses: got %0d want 1", fin_cnt - f0); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (miso !== 1'b1) $display("FAIL single_miso_idle: got %b want 1", miso); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] mi1, mi2;
    logic bo;
    int f0;
    f0 = fin_cnt;
    ss_low();
    exp_q.push_back(8'h3C);
    spi_bits(8'h3C, W, 1'b1, 8'h55, mi1, bo);
    exp_q.push_back(8'hC3);
    spi_bits(8'hC3, W, 1'b0, 8'h00, mi2, bo);
    ss_high();
    check_cnt++; if (mi1 !== 8'h41) $display("FAIL b2b_miso1: got %h want 41", mi1); else pass_cnt++;
    check_cnt++; if (mi2 !== 8'h55) $display("FAIL b2b_miso2: got %h want 55", mi2); else pass_cnt++;
    check_cnt++; if (q !== 8'hC3) $display("FAIL b2b_q: got %h want c3", q); else pass_cnt++;
    check_cnt++; if (fin_cnt - f0 != 2) $display("FAIL b2b_pulses: got %0d want 2", fin_cnt - f0); else pass_cnt++;
  endtask

  task automatic test_partial_frame();
    logic [W-1:0] mi;
    logic bo;
    int f0;
    f0 = fin_cnt;
    ss_low();
    spi_bits(8'hFF, 5, 1'b0, 8'h00, mi, bo);
    ss_high();
    check_cnt++; if (fin_cnt != f0) $display("FAIL partial_pulses: got %0d want 0", fin_cnt - f0); else pass_cnt++;
    check_cnt++; if (q !== 8'hC3) $display("FAIL partial_q: got %h want c3", q); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (miso !== 1'b1) $display("FAIL partial_miso: got %b want 1", miso); else pass_cnt++;
    ss_low();
    exp_q.push_back(8'h96);
    spi_bits(8'h96, W, 1'b0, 8'h00, mi, bo);
    ss_high();
    check_cnt++; if (q !== 8'h96) $display("FAIL partial_next_q: got %h want 96", q); else pass_cnt++;
    check_cnt++; if (mi !== 8'h55) $display("FAIL partial_next_miso: got %h want 55", mi); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] mi;
    logic bo;
    int f0;
    f0 = fin_cnt;
    ss_low();
    spi_bits(8'hAA, 4, 1'b0, 8'h00, mi, bo);
    reset = 1'b1;
    ss = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cnt++; if (miso !== 1'b1) $display("FAIL midreset_miso: got %b want 1", miso); else pass_cnt++;
    check_cnt++; if (q !== 8'h00) $display("FAIL midreset_q: got %h want 00", q); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else pass_cnt++;
    repeat (HALF) @(negedge clk);
    check_cnt++; if (fin_cnt != f0) $display("FAIL midreset_pulses: got %0d want 0", fin_cnt - f0); else pass_cnt++;
    pulse_load(8'hF0);
    ss_low();
    exp_q.push_back(8'h0F);
    spi_bits(8'h0F, W, 1'b0, 8'h00, mi, bo);
    ss_high();
    check_cnt++; if (q !== 8'h0F) $display("FAIL midreset_next_q: got %h want 0f", q); else pass_cnt++;
    check_cnt++; if (mi !== 8'hF0) $display("FAIL midreset_next_miso: got %h want f0", mi); else pass_cnt++;
  endtask

  task automatic test_retransmit();
    logic [W-1:0] mi1, mi2;
    logic bo;
    pulse_load(8'h41);
    ss_low();
    exp_q.push_back(8'h11);
    spi_bits(8'h11, W, 1'b0, 8'h00, mi1, bo);
    ss_high();
    ss_low();
    exp_q.push_back(8'h22);
    spi_bits(8'h22, W, 1'b0, 8'h00, mi2, bo);
    ss_high();
    check_cnt++; if (mi1 !== 8'h41) $display("FAIL retx_miso1: got %h want 41", mi1); else pass_cnt++;
    check_cnt++; if (mi2 !== 8'h41) $display("FAIL retx_miso2: got %h want 41", mi2); else pass_cnt++;
    check_cnt++; if (q !== 8'h22) $display("FAIL retx_q: got %h want 22", q); else pass_cnt++;
  endtask

  task automatic test_random_frames();
    logic [W-1:0] mo, ld, mi;
    logic bo;
    for (int n = 0; n < 4; n++) begin
      mo = W'($urandom_range(0, 255));
      ld = W'($urandom_range(0, 255));
      pulse_load(ld);
      ss_low();
      exp_q.push_back(mo);
      spi_bits(mo, W, 1'b0, 8'h00, mi, bo);
      ss_high();
      check_cnt++; if (mi !== ld) $display("FAIL rand_miso: got %h want %h", mi, ld); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_partial_frame();
    test_reset_mid_frame();
    test_retransmit();
    test_random_frames();
    repeat (4 * HALF) @(negedge clk);
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
